// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer. Produces the per-stage enables and flushes for
// the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It handles load-use
// stalls, taken-redirect flushes, and data-memory waits with a req/ack handshake
// and a timeout abort.
// Ports:
//   clk_PipeCtrl, rst_n_PipeCtrl        clock, async active-low reset
//   Rs1/Rs2_addr_ID, Rs1/Rs2_used_ID    source operands of the ID instruction
//   Rd_addr_EX, MemRead_EX              destination and load flag of the EX instruction
//   Redirect_EX                         taken branch/jump resolved in EX
//   Mem_access_MEM, Dmem_ack            memory access in MEM, completion from memory
//   en_*, flush_IFID, flush_IDEX        combinational stage controls, settle before negedge
//   Dmem_req, mem_err, stall_cnt        registered request, sticky timeout error,
//                                       saturating count of PC-stall cycles
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_PipeCtrl,
  input  logic             rst_n_PipeCtrl,
  input  logic [4:0]       Rs1_addr_ID,
  input  logic [4:0]       Rs2_addr_ID,
  input  logic             Rs1_used_ID,
  input  logic             Rs2_used_ID,
  input  logic [4:0]       Rd_addr_EX,
  input  logic             MemRead_EX,
  input  logic             Redirect_EX,
  input  logic             Mem_access_MEM,
  input  logic             Dmem_ack,
  output logic             en_PC,
  output logic             en_IFID,
  output logic             en_IDEX,
  output logic             en_ExMem,
  output logic             en_MemWB,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             Dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  state_e             state_q;
  logic [WAIT_W-1:0]  wait_cnt_q;
  logic               dmem_req_q;
  logic               mem_err_q;
  logic [CNT_W-1:0]   stall_cnt_q;

  logic load_use;
  logic mem_stall;
  logic en_pc_c, en_ifid_c, en_idex_c, en_exmem_c, en_memwb_c;
  logic flush_ifid_c, flush_idex_c;

  // Load in EX whose destination feeds an operand of the ID instruction
  assign load_use = MemRead_EX && (Rd_addr_EX != 5'd0) &&
                    ((Rs1_used_ID && (Rs1_addr_ID == Rd_addr_EX)) ||
                     (Rs2_used_ID && (Rs2_addr_ID == Rd_addr_EX)));

  // Freeze for memory: access starting in RUN, or still waiting with no ack and no timeout
  assign mem_stall = ((state_q == ST_RUN) && Mem_access_MEM) ||
                     ((state_q == ST_MEM_WAIT) && !Dmem_ack && (wait_cnt_q != WAIT_LAST));

  // Stage controls; redirect wins over load-use since the ID instruction is wrong-path
  always_comb begin
    en_pc_c      = 1'b1;
    en_ifid_c    = 1'b1;
    en_idex_c    = 1'b1;
    en_exmem_c   = 1'b1;
    en_memwb_c   = 1'b1;
    flush_ifid_c = 1'b0;
    flush_idex_c = 1'b0;
    if (mem_stall) begin
      en_pc_c    = 1'b0;
      en_ifid_c  = 1'b0;
      en_idex_c  = 1'b0;
      en_exmem_c = 1'b0;
      en_memwb_c = 1'b0;
    end else if (Redirect_EX) begin
      flush_ifid_c = 1'b1;
      flush_idex_c = 1'b1;
    end else if (load_use) begin
      en_pc_c      = 1'b0;
      en_ifid_c    = 1'b0;
      flush_idex_c = 1'b1;
    end
  end

  // Held low while reset is asserted
  assign en_PC      = en_pc_c      & rst_n_PipeCtrl;
  assign en_IFID    = en_ifid_c    & rst_n_PipeCtrl;
  assign en_IDEX    = en_idex_c    & rst_n_PipeCtrl;
  assign en_ExMem   = en_exmem_c   & rst_n_PipeCtrl;
  assign en_MemWB   = en_memwb_c   & rst_n_PipeCtrl;
  assign flush_IFID = flush_ifid_c & rst_n_PipeCtrl;
  assign flush_IDEX = flush_idex_c & rst_n_PipeCtrl;

  // Memory handshake FSM; ack beats timeout in the same cycle
  always_ff @(posedge clk_PipeCtrl or negedge rst_n_PipeCtrl) begin
    if (!rst_n_PipeCtrl) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      dmem_req_q <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (Mem_access_MEM) begin
            state_q    <= ST_MEM_WAIT;
            dmem_req_q <= 1'b1;
            wait_cnt_q <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (Dmem_ack) begin
            state_q    <= ST_RUN;
            dmem_req_q <= 1'b0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q    <= ST_RUN;
            dmem_req_q <= 1'b0;
            mem_err_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Saturating count of cycles with the PC frozen
  always_ff @(posedge clk_PipeCtrl or negedge rst_n_PipeCtrl) begin
    if (!rst_n_PipeCtrl) begin
      stall_cnt_q <= '0;
    end else if (!en_pc_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign Dmem_req  = dmem_req_q;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates the per-stage enable and flush strobes that those registers consume.
- Resolves three cases: load-use stalls, taken-branch/jump flushes, and multi-cycle data-memory accesses through a req/ack handshake with timeout.
- Sits beside the datapath in the top-level CPU and replaces the tie-high enables of the no-stall build.

Parameters:
TIMEOUT, 16, max cycles to wait for Dmem_ack before aborting the access
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk_PipeCtrl  input  1  clock; controller state updates on rising edge
rst_n_PipeCtrl  input  1  asynchronous, active-low reset
Rs1_addr_ID  input  5  rs1 of the instruction in ID
Rs2_addr_ID  input  5  rs2 of the instruction in ID
Rs1_used_ID  input  1  ID instruction reads rs1
Rs2_used_ID  input  1  ID instruction reads rs2
Rd_addr_EX  input  5  destination of the instruction in EX
MemRead_EX  input  1  EX instruction is a load
Redirect_EX  input  1  taken branch or jump resolved in EX
Mem_access_MEM  input  1  MEM instruction performs a load or store
Dmem_ack  input  1  data memory completes the access
en_PC  output  1  PC update enable
en_IFID  output  1  IF/ID enable
en_IDEX  output  1  ID/EX enable
en_ExMem  output  1  EX/MEM enable
en_MemWB  output  1  MEM/WB enable
flush_IFID  output  1  IF/ID captures a NOP
flush_IDEX  output  1  ID/EX captures a bubble
Dmem_req  output  1  registered request to data memory
mem_err  output  1  sticky; set when an access times out
stall_cnt  output  CNT_W  saturating count of cycles with en_PC=0

Behaviour:
- Reset (rst_n_PipeCtrl=0, asynchronous):
  - state=RUN.
  - wait_cnt=0, stall_cnt=0, Dmem_req=0, mem_err=0.
  - All en_* and flush_* are forced to 0 while reset is held.
- State and outputs:
  - FSM states: RUN, MEM_WAIT. Only state, wait_cnt, Dmem_req, mem_err and stall_cnt are registers.
  - Enables and flushes are combinational from state and inputs. They must settle within the first half-cycle, because the pipeline registers sample on the falling edge.
- RUN, Mem_access_MEM=1:
  - All five enables = 0; flushes = 0.
  - Next state MEM_WAIT; Dmem_req<=1; wait_cnt<=0.
  - This rule takes precedence over redirect and load-use.
- MEM_WAIT:
  - Dmem_req stays 1.
  - If Dmem_ack=0 and wait_cnt<TIMEOUT-1: all enables 0, wait_cnt increments.
  - If Dmem_ack=1: all enables 1, Dmem_req<=0, next state RUN. Redirect and load-use rules apply in that same cycle.
  - If wait_cnt reaches TIMEOUT-1 with no ack: mem_err<=1 (sticky until reset), enables 1, Dmem_req<=0, return to RUN.
  - Ack and timeout in the same cycle: ack wins; mem_err is not set.
- Pipeline advance when not stalled for memory (RUN with Mem_access_MEM=0, or the release cycle of MEM_WAIT):
  - Redirect_EX=1: all enables 1, flush_IFID=1, flush_IDEX=1. This overrides load-use, because the ID instruction is wrong-path.
  - Load-use hazard, defined as MemRead_EX=1, Rd_addr_EX≠0, and (Rs1_used_ID and Rs1_addr_ID==Rd_addr_EX, or Rs2_used_ID and Rs2_addr_ID==Rd_addr_EX):
    - en_PC=0, en_IFID=0.
    - en_IDEX=1 with flush_IDEX=1 (bubble inserted).
    - en_ExMem=1, en_MemWB=1.
  - Otherwise: all enables 1, no flush.
- Release-cycle re-entry: after a release, the next RUN cycle re-evaluates Mem_access_MEM for the newly arrived instruction. Back-to-back memory instructions therefore each get their own wait.
- stall_cnt: increments on every rising edge where en_PC=0 and not in reset; saturates at all-ones.
- Ack handling: Dmem_ack seen in RUN is ignored. A spurious ack must not change state.

Test Plan:
- Load-use: MemRead_EX=1, Rd_addr_EX=5, Rs1_addr_ID=5, Rs1_used_ID=1 -> en_PC=0, en_IFID=0, flush_IDEX=1, en_ExMem=1 for exactly 1 cycle; stall_cnt=1. Repeat with Rd_addr_EX=0 -> no stall.
- Redirect plus load-use together: Redirect_EX=1 with the hazard above -> flush_IFID=1, flush_IDEX=1, en_PC=1, stall_cnt unchanged.
- Memory wait: Mem_access_MEM=1, Dmem_ack raised 3 cycles after Dmem_req -> all enables 0 for 4 cycles, release on the ack cycle, Dmem_req falls on the next edge, stall_cnt=4.
- Timeout: TIMEOUT=4, Dmem_ack held 0 -> mem_err=1 after 5 rising edges and stays 1; enables 1 on the abort cycle; FSM back in RUN.
- Async reset mid-wait: assert rst_n_PipeCtrl=0 between edges while in MEM_WAIT -> Dmem_req, mem_err, stall_cnt and all enables go to 0 immediately; after release, FSM is in RUN.
- Saturation: CNT_W=4, hold a memory stall for 20 cycles -> stall_cnt sticks at 15.
